axi_lite_to_reg_intf: RTL and testbench
=======================================

# axi_lite_to_reg_intf

AXI4-Lite slave that converts AXI4-Lite transactions into register-interface (`reg_req`/`reg_rsp`) requests. It is the inverse of the reg-to-AXI-Lite bridge in front of SAURIA's configuration port. It lets an AXI4-Lite master, such as a debug or DMA-side config path, drive any register-interface peripheral. The block holds one outstanding write and one outstanding read, arbitrates fairly between them, and serialises them onto the single register port.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: AXI and reg address width.
- `DATA_WIDTH`, default 32: data width; must be 32 or 64.
- `STRB_WIDTH`, localparam, `DATA_WIDTH/8`.

Ports:
- `clk_i`  in  1  clock; the only clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `awaddr_i`  in  `ADDR_WIDTH`  write address.
- `awprot_i`  in  3  ignored.
- `awvalid_i` in 1; `awready_o` out 1  AW handshake.
- `wdata_i`  in  `DATA_WIDTH`  write data.
- `wstrb_i`  in  `STRB_WIDTH`  write strobes.
- `wvalid_i` in 1; `wready_o` out 1  W handshake.
- `bresp_o`  out  2  write response.
- `bvalid_o` out 1; `bready_i` in 1  B handshake.
- `araddr_i`  in  `ADDR_WIDTH`  read address.
- `arprot_i`  in  3  ignored.
- `arvalid_i` in 1; `arready_o` out 1  AR handshake.
- `rdata_o`  out  `DATA_WIDTH`  read data.
- `rresp_o`  out  2  read response.
- `rvalid_o` out 1; `rready_i` in 1  R handshake.
- `reg_addr_o`  out  `ADDR_WIDTH`  reg request address.
- `reg_write_o`  out  1  1 = write, 0 = read.
- `reg_wdata_o`  out  `DATA_WIDTH`  write data.
- `reg_wstrb_o`  out  `STRB_WIDTH`  write strobes.
- `reg_valid_o`  out  1  request valid.
- `reg_rdata_i`  in  `DATA_WIDTH`  read data.
- `reg_error_i`  in  1  error flag, sampled with ready.
- `reg_ready_i`  in  1  request accepted and completed this cycle.

## Operation

- Three single-entry holding registers, `aw_q`, `w_q` and `ar_q`, each with a full flag.
  - `awready_o = !aw_full & !rst_i`; `wready_o` and `arready_o` follow the same rule with their own flags.
  - AW and W are captured independently, in any order, including the same cycle.
- A write is pending when both `aw_full` and `w_full` are set. A read is pending when `ar_full` is set.
- FSM states: `IDLE`, `WR_REQ`, `RD_REQ`, `WR_RSP`, `RD_RSP`.
  - `IDLE`:
    - Write pending only → `WR_REQ`. Read pending only → `RD_REQ`.
    - Both pending → arbitrate with the `last_wr` bit. Read wins if `last_wr` = 1, otherwise write wins.
    - `last_wr` resets to 0, so write wins the first tie.
    - Neither pending → stay in `IDLE`.
  - `WR_REQ`:
    - `reg_valid_o` = 1, `reg_write_o` = 1; addr, wdata and wstrb come from the buffers.
    - On `reg_ready_i`: latch `reg_error_i`, set `last_wr` = 1, go to `WR_RSP`.
  - `RD_REQ`:
    - `reg_valid_o` = 1, `reg_write_o` = 0; `reg_wdata_o` and `reg_wstrb_o` are driven 0.
    - On `reg_ready_i`: latch `reg_rdata_i` and `reg_error_i`, set `last_wr` = 0, go to `RD_RSP`.
  - `WR_RSP`:
    - `bvalid_o` = 1. `bresp_o` = 2'b10 (SLVERR) if the latched error is set, else 2'b00 (OKAY).
    - On `bready_i`: clear `aw_full` and `w_full`, go to `IDLE`.
  - `RD_RSP`:
    - `rvalid_o` = 1; `rdata_o` is the latched data; `rresp_o` is encoded like `bresp_o`.
    - On `rready_i`: clear `ar_full`, go to `IDLE`.
- Request outputs stay stable while `reg_valid_o` = 1 and `reg_ready_i` = 0. There is no timeout.
- `wstrb` = 0 is forwarded unchanged; it is not filtered.
- `rdata_o` on an error response carries whatever was sampled from `reg_rdata_i`.
- The AR buffer may fill while a write is in flight, and vice versa. The next request is served after return to `IDLE`.

## Timing

- Reset values:
  - All valid outputs 0; all AXI ready outputs 0 while `rst_i` = 1.
  - `bresp_o`, `rresp_o`, `rdata_o`, `reg_*` outputs all 0.
  - All full flags 0; FSM in `IDLE`; `last_wr` = 0.
- Reset asserted mid-transaction aborts it immediately and asynchronously. The in-flight `reg_valid_o` drops, and no response is ever issued for the aborted request.
- The first cycle after `rst_i` deasserts has `awready_o`, `wready_o` and `arready_o` all = 1.
- Latency: handshake at edge N → `reg_valid_o` high after edge N+1. With `reg_ready_i` = 1 in that cycle, `bvalid_o`/`rvalid_o` go high after edge N+2. Minimum handshake-to-response is 2 cycles.
- Write latency counts from the later of the AW and W handshakes.
- Throughput is one reg transaction per 3 cycles minimum (REQ, RSP, IDLE).
- Buffer refill: `awready_o` returns to 1 the cycle after the B handshake.
- A simultaneous AW, W and AR handshake in the same cycle is accepted: all three flags set.
- All outputs are registered, or decoded from state plus registers only. There are no combinational paths from AXI inputs to AXI outputs.

## Test plan

- Single write: AW addr 0x40 and W data 0xDEADBEEF, strb 0xF, in the same cycle, `reg_ready_i` tied 1.
  - Required: `reg_valid_o` high exactly 1 cycle with `reg_write_o` = 1, addr 0x40, wdata 0xDEADBEEF.
  - Required: `bvalid_o` high 2 cycles after the handshake, `bresp_o` = 0.
- W before AW: W data 0x1234 at cycle 0, AW addr 0x8 at cycle 3.
  - Required: no `reg_valid_o` before cycle 4; request carries data 0x1234 and addr 0x8.
- Read with stall and error: AR addr 0x10; `reg_ready_i` low 5 cycles, then high with `reg_rdata_i` 0xCAFE and `reg_error_i` = 1.
  - Required: `reg_addr_o` stable for 6 cycles; `rvalid_o` with `rdata_o` 0xCAFE and `rresp_o` 2'b10.
- Arbitration: write and read pending simultaneously from reset, repeated 4 times.
  - Required: reg order W, R, W, R, W, R, W, R.
- Backpressure: `bready_i` held low 10 cycles after `bvalid_o`.
  - Required: `bvalid_o` and `bresp_o` stable; `awready_o` = 0 throughout; a second AW is accepted only after the B handshake.
- Reset mid-request: assert `rst_i` while `reg_valid_o` = 1.
  - Required: `reg_valid_o`, `bvalid_o` and `rvalid_o` go 0 the same cycle; no response follows release; a fresh write then completes normally.

Source files
------------

// File: rtl/axi_lite_to_reg_intf.sv
// axi_lite_to_reg_intf: AXI4-Lite slave that serialises one write and one read onto a register-interface port.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   aw*/w*/b*                         AXI4-Lite write address, write data, write response channels
//   ar*/r*                            AXI4-Lite read address and read data channels
//   reg_addr_o/reg_write_o/reg_wdata_o/reg_wstrb_o/reg_valid_o   register request
//   reg_rdata_i/reg_error_i/reg_ready_i                          register response
module axi_lite_to_reg_intf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [2:0]            awprot_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [2:0]            arprot_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic                  reg_write_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic [STRB_WIDTH-1:0] reg_wstrb_o,
    output logic                  reg_valid_o,
    input  logic [DATA_WIDTH-1:0] reg_rdata_i,
    input  logic                  reg_error_i,
    input  logic                  reg_ready_i
);
    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RSP, RD_RSP} state_t;
    state_t                state;
    logic                  aw_full, w_full, ar_full, last_wr;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  wr_pend, rd_pend;
    logic                  unused_prot;
    assign unused_prot = ^{awprot_i, arprot_i};
    assign awready_o   = !aw_full & !rst_i;
    assign wready_o    = !w_full & !rst_i;
    assign arready_o   = !ar_full & !rst_i;
    assign wr_pend     = aw_full & w_full;
    assign rd_pend     = ar_full;
    // A full buffer never accepts, so a capture and a clear of the same flag cannot coincide.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            ar_full     <= 1'b0;
            last_wr     <= 1'b0;
            aw_addr     <= '0;
            ar_addr     <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            reg_valid_o <= 1'b0;
            reg_write_o <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_wstrb_o <= '0;
            bvalid_o    <= 1'b0;
            bresp_o     <= 2'b00;
            rvalid_o    <= 1'b0;
            rresp_o     <= 2'b00;
            rdata_o     <= '0;
        end else begin
            if (awvalid_i && awready_o) begin
                aw_full <= 1'b1;
                aw_addr <= awaddr_i;
            end
            if (wvalid_i && wready_o) begin
                w_full <= 1'b1;
                w_data <= wdata_i;
                w_strb <= wstrb_i;
            end
            if (arvalid_i && arready_o) begin
                ar_full <= 1'b1;
                ar_addr <= araddr_i;
            end
            case (state)
                IDLE: begin
                    // On a tie the side not served last goes first.
                    if (wr_pend && (!rd_pend || !last_wr)) begin
                        state       <= WR_REQ;
                        reg_valid_o <= 1'b1;
                        reg_write_o <= 1'b1;
                        reg_addr_o  <= aw_addr;
                        reg_wdata_o <= w_data;
                        reg_wstrb_o <= w_strb;
                    end else if (rd_pend) begin
                        state       <= RD_REQ;
                        reg_valid_o <= 1'b1;
                        reg_write_o <= 1'b0;
                        reg_addr_o  <= ar_addr;
                        reg_wdata_o <= '0;
                        reg_wstrb_o <= '0;
                    end
                end
                WR_REQ: begin
                    if (reg_ready_i) begin
                        state       <= WR_RSP;
                        last_wr     <= 1'b1;
                        reg_valid_o <= 1'b0;
                        reg_write_o <= 1'b0;
                        reg_addr_o  <= '0;
                        reg_wdata_o <= '0;
                        reg_wstrb_o <= '0;
                        bvalid_o    <= 1'b1;
                        bresp_o     <= reg_error_i ? 2'b10 : 2'b00;
                    end
                end
                RD_REQ: begin
                    if (reg_ready_i) begin
                        state       <= RD_RSP;
                        last_wr     <= 1'b0;
                        reg_valid_o <= 1'b0;
                        reg_addr_o  <= '0;
                        rvalid_o    <= 1'b1;
                        rresp_o     <= reg_error_i ? 2'b10 : 2'b00;
                        rdata_o     <= reg_rdata_i;
                    end
                end
                WR_RSP: begin
                    if (bready_i) begin
                        state    <= IDLE;
                        bvalid_o <= 1'b0;
                        bresp_o  <= 2'b00;
                        aw_full  <= 1'b0;
                        w_full   <= 1'b0;
                    end
                end
                RD_RSP: begin
                    if (rready_i) begin
                        state    <= IDLE;
                        rvalid_o <= 1'b0;
                        rresp_o  <= 2'b00;
                        ar_full  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_to_reg_intf.sv
// tb_axi_lite_to_reg_intf: vector table, directed corner sequences and randomized traffic against a transaction-order model.
module tb_axi_lite_to_reg_intf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata, reg_addr, reg_wdata, reg_rdata = '0;
    logic [3:0]  wstrb = '0, reg_wstrb;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
    logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0;
    logic [1:0]  bresp, rresp;
    logic        reg_write, reg_valid, reg_error = 1'b0, reg_ready = 1'b0;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[5];

    axi_lite_to_reg_intf dut (
        .clk_i(clk), .rst_i(rst),
        .awaddr_i(awaddr), .awprot_i(awprot), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
        .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .araddr_i(araddr), .arprot_i(arprot), .arvalid_i(arvalid), .arready_o(arready),
        .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
        .reg_addr_o(reg_addr), .reg_write_o(reg_write), .reg_wdata_o(reg_wdata),
        .reg_wstrb_o(reg_wstrb), .reg_valid_o(reg_valid),
        .reg_rdata_i(reg_rdata), .reg_error_i(reg_error), .reg_ready_i(reg_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0; reg_ready = 1'b0; reg_error = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        awaddr = v.addr; wdata = v.data; wstrb = v.strb; araddr = v.addr;
        awvalid = v.wr; wvalid = v.wr; arvalid = !v.wr;
        reg_ready = 1'b1; reg_rdata = v.rdata; reg_error = v.err;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk($sformatf("v%0d_no_early_valid", i), 64'(reg_valid), 64'd0);
        tick();
        chk($sformatf("v%0d_reg_valid", i), 64'(reg_valid), 64'd1);
        chk($sformatf("v%0d_reg_write", i), 64'(reg_write), 64'(v.wr));
        chk($sformatf("v%0d_reg_addr", i), 64'(reg_addr), 64'(v.addr));
        chk($sformatf("v%0d_reg_wdata", i), 64'(reg_wdata), 64'(v.wr ? v.data : 32'h0));
        chk($sformatf("v%0d_reg_wstrb", i), 64'(reg_wstrb), 64'(v.wr ? v.strb : 4'h0));
        tick();
        chk($sformatf("v%0d_reg_valid_drop", i), 64'(reg_valid), 64'd0);
        chk($sformatf("v%0d_bvalid", i), 64'(bvalid), 64'(v.wr));
        chk($sformatf("v%0d_rvalid", i), 64'(rvalid), 64'(!v.wr));
        if (v.wr) chk($sformatf("v%0d_bresp", i), 64'(bresp), 64'(v.exp_resp));
        else begin
            chk($sformatf("v%0d_rresp", i), 64'(rresp), 64'(v.exp_resp));
            chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(v.exp_rdata));
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        chk($sformatf("v%0d_rsp_done", i), 64'({bvalid, rvalid}), 64'd0);
        chk($sformatf("v%0d_refill", i), 64'({awready, wready, arready}), 64'h7);
        idle_inputs();
    endtask

    // Model: requests are served in the order they become complete; a tie goes to the
    // kind that was not served most recently. Responses echo what the slave returned.
    task automatic rand_test;
        int          kind, aw_off, w_off, ar_off, wp, got;
        logic        hw, hr, w_first, exp_is_w, m_last_wr, w_done, r_done, berr, rerr;
        logic [31:0] a_w, d_w, a_r, exp_rd;
        logic [3:0]  s_w;
        m_last_wr = 1'b0;
        berr = 1'b0; rerr = 1'b0; exp_rd = '0;
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 2);
            hw = (kind != 1); hr = (kind != 0);
            aw_off = $urandom_range(0, 1); w_off = $urandom_range(0, 1); ar_off = $urandom_range(0, 1);
            a_w = $urandom; d_w = $urandom; s_w = 4'($urandom); a_r = $urandom;
            wp = (aw_off > w_off) ? aw_off : w_off;
            w_first = hw && (!hr || wp < ar_off || (wp == ar_off && !m_last_wr));
            awaddr = a_w; wdata = d_w; wstrb = s_w; araddr = a_r;
            got = 0; w_done = !hw; r_done = !hr;
            for (int c = 0; c < 80 && !(w_done && r_done); c++) begin
                awvalid = hw && c == aw_off;
                wvalid = hw && c == w_off;
                arvalid = hr && c == ar_off;
                reg_ready = $urandom_range(0, 2) != 0;
                reg_rdata = $urandom;
                reg_error = $urandom_range(0, 3) == 0;
                bready = $urandom_range(0, 1) != 0;
                rready = $urandom_range(0, 1) != 0;
                if (reg_valid && reg_ready) begin
                    exp_is_w = (got == 0) ? w_first : !w_first;
                    chk("rnd_req_kind", 64'(reg_write), 64'(exp_is_w));
                    chk("rnd_req_addr", 64'(reg_addr), 64'(exp_is_w ? a_w : a_r));
                    chk("rnd_req_wdata", 64'(reg_wdata), 64'(exp_is_w ? d_w : 32'h0));
                    chk("rnd_req_wstrb", 64'(reg_wstrb), 64'(exp_is_w ? s_w : 4'h0));
                    if (exp_is_w) berr = reg_error;
                    else begin
                        rerr = reg_error;
                        exp_rd = reg_rdata;
                    end
                    got++;
                end
                if (bvalid && bready) begin
                    chk("rnd_bresp", 64'(bresp), 64'(berr ? 2'b10 : 2'b00));
                    w_done = 1'b1;
                end
                if (rvalid && rready) begin
                    chk("rnd_rresp", 64'(rresp), 64'(rerr ? 2'b10 : 2'b00));
                    chk("rnd_rdata", 64'(rdata), 64'(exp_rd));
                    r_done = 1'b1;
                end
                tick();
            end
            n_chk++;
            if (!(w_done && r_done)) begin
                n_fail++;
                $display("FAIL rnd_timeout it=%0d: got responses w=%0d r=%0d required both", it, w_done, r_done);
            end
            m_last_wr = hw && (!hr || !w_first);
            idle_inputs();
        end
    endtask

    initial begin
        logic [7:0] order;
        int         n_ord;
        vecs[0] = '{wr:1'b1, addr:32'h40, data:32'hDEADBEEF, strb:4'hF, rdata:32'h0, err:1'b0, exp_resp:2'b00, exp_rdata:32'h0};
        vecs[1] = '{wr:1'b0, addr:32'h44, data:32'h0, strb:4'h0, rdata:32'h12345678, err:1'b0, exp_resp:2'b00, exp_rdata:32'h12345678};
        vecs[2] = '{wr:1'b1, addr:32'h80, data:32'h0BAD_F00D, strb:4'h0, rdata:32'h0, err:1'b1, exp_resp:2'b10, exp_rdata:32'h0};
        vecs[3] = '{wr:1'b0, addr:32'hFFFF_FFFC, data:32'h0, strb:4'h0, rdata:32'hA5A5A5A5, err:1'b1, exp_resp:2'b10, exp_rdata:32'hA5A5A5A5};
        vecs[4] = '{wr:1'b1, addr:32'hFFFF_FFFC, data:32'hFFFF_FFFF, strb:4'h5, rdata:32'h0, err:1'b0, exp_resp:2'b00, exp_rdata:32'h0};

        tick();
        chk("rst_readies", 64'({awready, wready, arready}), 64'd0);
        chk("rst_valids", 64'({reg_valid, bvalid, rvalid}), 64'd0);
        chk("rst_resps", 64'({bresp, rresp}), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_reg_bus", 64'({reg_addr, reg_wdata}), 64'd0);
        chk("rst_reg_misc", 64'({reg_write, reg_wstrb}), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_readies", 64'({awready, wready, arready}), 64'h7);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // W before AW
        do_reset();
        wdata = 32'h1234; wstrb = 4'hF; awaddr = 32'h8; wvalid = 1'b1; reg_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            awvalid = (c == 3);
            tick();
            wvalid = 1'b0;
            chk($sformatf("wfirst_quiet_c%0d", c), 64'(reg_valid), 64'd0);
        end
        awvalid = 1'b0;
        tick();
        chk("wfirst_valid", 64'(reg_valid), 64'd1);
        chk("wfirst_addr", 64'(reg_addr), 64'h8);
        chk("wfirst_data", 64'(reg_wdata), 64'h1234);
        tick();
        chk("wfirst_bvalid", 64'(bvalid), 64'd1);

        // Read stalled by the slave, completing with an error
        do_reset();
        araddr = 32'h10; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("stall_valid_c%0d", c), 64'(reg_valid), 64'd1);
            chk($sformatf("stall_addr_c%0d", c), 64'({reg_write, reg_addr}), 64'h10);
            chk($sformatf("stall_no_rsp_c%0d", c), 64'(rvalid), 64'd0);
            if (c == 5) begin
                reg_ready = 1'b1; reg_rdata = 32'hCAFE; reg_error = 1'b1;
            end
            tick();
        end
        chk("stall_rvalid", 64'(rvalid), 64'd1);
        chk("stall_rdata", 64'(rdata), 64'hCAFE);
        chk("stall_rresp", 64'(rresp), 64'h2);
        rready = 1'b1;
        tick();
        chk("stall_rdone", 64'(rvalid), 64'd0);

        // Fair arbitration with both kinds continuously pending
        do_reset();
        awaddr = 32'h100; wdata = 32'h77; araddr = 32'h200;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        reg_ready = 1'b1; bready = 1'b1; rready = 1'b1;
        order = '0; n_ord = 0;
        for (int c = 0; c < 80 && n_ord < 8; c++) begin
            tick();
            if (reg_valid) begin
                order[n_ord] = reg_write;
                n_ord++;
            end
        end
        chk("arb_count", 64'(n_ord), 64'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("arb_order_%0d", i), 64'(order[i]), 64'(i % 2 == 0));

        // Write response backpressure
        do_reset();
        awaddr = 32'h300; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; reg_ready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        tick();
        awaddr = 32'h304; wdata = 32'h66; awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp_bvalid_c%0d", c), 64'({bvalid, bresp}), 64'h4);
            chk($sformatf("bp_awready_c%0d", c), 64'(awready), 64'd0);
            chk($sformatf("bp_no_req_c%0d", c), 64'(reg_valid), 64'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bp_b_done", 64'(bvalid), 64'd0);
        chk("bp_refill", 64'(awready), 64'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_second_taken", 64'(awready), 64'd0);
        tick();
        chk("bp_second_valid", 64'(reg_valid), 64'd1);
        chk("bp_second_addr", 64'(reg_addr), 64'h304);
        chk("bp_second_data", 64'(reg_wdata), 64'h66);

        // Reset in the middle of a stalled request
        do_reset();
        awaddr = 32'h500; wdata = 32'h99; awvalid = 1'b1; wvalid = 1'b1; araddr = 32'h504; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        chk("mid_valid_before", 64'(reg_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_async_drop", 64'({reg_valid, bvalid, rvalid}), 64'd0);
        chk("mid_readies_low", 64'({awready, wready, arready}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reg_ready = 1'b1; bready = 1'b1; rready = 1'b1;
        #1;
        chk("mid_rel_readies", 64'({awready, wready, arready}), 64'h7);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("mid_silent_c%0d", c), 64'({reg_valid, bvalid, rvalid}), 64'd0);
        end
        idle_inputs();
        run_vec(0, vecs[0]);

        do_reset();
        rand_test();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
